int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Machine-mode interrupt controller; the producer side of the CSR unit's interrupt interface.
- Collects software, timer and external interrupt lines and builds the MIP image fed to the CSR unit.
- Arbitrates by priority and requests a trap from the pipeline. On pipeline acknowledge it issues the one-cycle interrupt_taken pulse, together with cause, interrupted PC and handler target.

Parameters:
- NUM_EXT, 4: number of external interrupt lines, 1..16. Line i is reported at MIP bit 16+i.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ext_irq  in  NUM_EXT  external interrupt lines, synchronous to clk.
- timer_irq  in  1  machine timer interrupt, level.
- sw_irq  in  1  machine software interrupt, level.
- mie  in  32  machine interrupt enable from CSR unit.
- global_int_enable  in  1  mstatus.MIE from CSR unit.
- mtvec  in  32  trap vector from CSR unit.
- int_ack  in  1  pipeline at a safe point and accepting the request.
- ack_pc  in  32  PC to resume at; valid with int_ack.
- int_req  out  1  trap request to pipeline.
- mip_out  out  32  pending image to CSR unit (mip_in).
- interrupt_taken  out  1  one-cycle pulse to CSR unit and pipeline.
- interrupt_cause  out  32  mcause value.
- interrupt_pc  out  32  mepc value.
- trap_pc  out  32  handler fetch address.

Behaviour:
- Reset: while reset==0 at a clk edge, all outputs 0, state IDLE, edge-pending bits cleared.
- mip_out is registered, updated every cycle:
  - bit3 = sw_irq
  - bit7 = timer_irq
  - bit(16+i) = ext pending i
  - bit11 = OR of all ext pending bits
  - all other bits 0.
- Line enables:
  - sw enabled = mie[3]; timer enabled = mie[7].
  - ext line i enabled = mie[11] & mie[16+i].
- Priority: ext (lowest index first) > sw > timer.
- Causes:
  - ext i: 0x80000000|(16+i).
  - sw: 0x80000003.
  - timer: 0x80000007.
- eligible = global_int_enable & (any enabled pending bit in mip_out).
- States: IDLE, REQ, TAKEN, BLOCK.
  - IDLE: eligible -> REQ and load cur_cause with the top-priority cause.
  - REQ: int_req=1.
    - int_ack=1 -> TAKEN; latch interrupt_cause=cur_cause, interrupt_pc=ack_pc.
    - else if !eligible -> IDLE (request withdrawn).
    - else stay in REQ and reload cur_cause each cycle, so a higher-priority arrival preempts before ack.
  - TAKEN: interrupt_taken=1 for exactly one cycle, int_req=0 -> BLOCK.
  - BLOCK: one cycle, covers the CSR clearing mstatus.MIE -> IDLE.
- Latency: irq rise at edge N -> mip_out at N+1 -> int_req at N+2 (if enabled).
- Ack and withdrawal in the same cycle: ack wins, with cause as presented.
- int_ack outside REQ: ignored.
- trap_pc, latched in TAKEN:
  - mtvec[1:0]==1 (vectored): {mtvec[31:2],2'b00} + 4*cause[4:0].
  - otherwise: {mtvec[31:2],2'b00}.
- interrupt_cause, interrupt_pc and trap_pc hold their values until the next take.
- Reset mid-request (any state): returns to IDLE next edge; no taken pulse is emitted.

Optional Feature:
- Macro INTC_EDGE_TRIG_EN.
- Defined:
  - ext pending bit i sets on a rising edge of ext_irq[i] (registered previous value) and is sticky.
  - The bit clears in TAKEN when interrupt_cause selects line i.
  - If a new edge arrives in the same cycle as the clear, set wins.
- Undefined: ext pending i = ext_irq[i] (level). The handler must quiesce the source; no clear logic exists.

Test Plan:
- Basic timer take:
  - Setup: mie=0x80, global_int_enable=1, mtvec=0x100; timer_irq rises.
  - Required: int_req 2 cycles later; ack with ack_pc=0x2040 -> next cycle interrupt_taken=1, cause=0x80000007, interrupt_pc=0x2040, trap_pc=0x100, then int_req=0 for at least 2 cycles.
- Vectored external:
  - Setup: mtvec=0x201, mie=0x00020800, ext_irq[1]=1.
  - Required: cause=0x80000011, trap_pc=0x244, mip_out=0x00020800.
- Priority and preemption:
  - Setup: sw and timer pending, mie=0x88; ext_irq[0] rises while in REQ; mie also has 0x00010800.
  - Required: cause at ack = 0x80000010; with ext_irq low the cause would be 0x80000003.
- Withdrawal:
  - Setup: REQ on timer; timer_irq drops before ack.
  - Required: int_req falls (one cycle after mip_out bit7 clears); a later int_ack produces no interrupt_taken.
- Gating and reset:
  - Setup: global_int_enable=0 with timer pending.
  - Required: int_req stays 0 while mip_out bit7 stays 1.
  - Stimulus: reset=0 for one edge while in REQ.
  - Required: all outputs 0 and no taken pulse.
- Edge mode (INTC_EDGE_TRIG_EN):
  - Stimulus: 1-cycle pulse on ext_irq[2].
  - Required: mip_out bit18 sticks and clears only after the taken cycle for cause 0x80000012.

Source files
------------

// File: rtl/int_ctrl.sv
// Machine-mode interrupt controller: builds the MIP image, picks the highest-priority enabled
// interrupt and hands a trap to the pipeline. Define INTC_EDGE_TRIG_EN for sticky edge-triggered external lines.
module int_ctrl #(
  parameter int NUM_EXT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               timer_irq,
  input  logic               sw_irq,
  input  logic [31:0]        mie,
  input  logic               global_int_enable,
  input  logic [31:0]        mtvec,
  input  logic               int_ack,
  input  logic [31:0]        ack_pc,
  output logic               int_req,
  output logic [31:0]        mip_out,
  output logic               interrupt_taken,
  output logic [31:0]        interrupt_cause,
  output logic [31:0]        interrupt_pc,
  output logic [31:0]        trap_pc
);

  localparam logic [31:0] CAUSE_INT   = 32'h8000_0000;
  localparam logic [31:0] CAUSE_SW    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  typedef enum logic [1:0] {IDLE, REQ, TAKEN, BLOCK} state_t;

  state_t             state;
  logic [31:0]        cur_cause;
  logic [31:0]        en_mask;
  logic [31:0]        mip_next;
  logic [31:0]        top_cause;
  logic [NUM_EXT-1:0] ext_pend_next;
  logic               eligible;
  logic               unused_mie;

  // Lowest external index wins, then software, then timer.
  function automatic logic [31:0] pick_cause(input logic [31:0] pend);
    logic [31:0] c;
    c = '0;
    if (pend[7]) c = CAUSE_TIMER;
    if (pend[3]) c = CAUSE_SW;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (pend[16+i]) c = CAUSE_INT | 32'(16 + i);
    end
    return c;
  endfunction

  function automatic logic [31:0] handler_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (tvec[1:0] == 2'b01) base = base + {25'd0, cause[4:0], 2'b00};
    return base;
  endfunction

  assign unused_mie = ^mie;

  always_comb begin
    en_mask    = '0;
    en_mask[3] = mie[3];
    en_mask[7] = mie[7];
    for (int i = 0; i < NUM_EXT; i++) begin
      en_mask[16+i] = mie[11] & mie[16+i];
    end
  end

  assign eligible  = global_int_enable & (|(mip_out & en_mask));
  assign top_cause = pick_cause(mip_out & en_mask);

`ifdef INTC_EDGE_TRIG_EN
  logic [NUM_EXT-1:0] ext_prev;
  logic [NUM_EXT-1:0] ext_clr;

  // The sticky pending bits live in mip_out itself; a fresh edge beats a same-cycle clear.
  always_comb begin
    ext_clr = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      ext_clr[i] = (state == TAKEN) && (interrupt_cause == (CAUSE_INT | 32'(16 + i)));
    end
    ext_pend_next = (mip_out[16 +: NUM_EXT] & ~ext_clr) | (ext_irq & ~ext_prev);
  end

  always_ff @(posedge clk) begin
    if (!reset) ext_prev <= '0;
    else        ext_prev <= ext_irq;
  end
`else
  assign ext_pend_next = ext_irq;
`endif

  always_comb begin
    mip_next                 = '0;
    mip_next[3]              = sw_irq;
    mip_next[7]              = timer_irq;
    mip_next[11]             = |ext_pend_next;
    mip_next[16 +: NUM_EXT]  = ext_pend_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      int_req         <= 1'b0;
      interrupt_taken <= 1'b0;
      cur_cause       <= '0;
      interrupt_cause <= '0;
      interrupt_pc    <= '0;
      trap_pc         <= '0;
      mip_out         <= '0;
    end else begin
      mip_out         <= mip_next;
      interrupt_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (eligible) begin
            state     <= REQ;
            int_req   <= 1'b1;
            cur_cause <= top_cause;
          end
        end
        REQ: begin
          if (int_ack) begin
            state           <= TAKEN;
            int_req         <= 1'b0;
            interrupt_taken <= 1'b1;
            interrupt_cause <= cur_cause;
            interrupt_pc    <= ack_pc;
            trap_pc         <= handler_target(mtvec, cur_cause);
          end else if (!eligible) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end else begin
            cur_cause <= top_cause;
          end
        end
        // One quiet cycle after the take lets the CSR unit drop mstatus.MIE.
        TAKEN:   state <= BLOCK;
        BLOCK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic compared against a cycle-level reference model.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ext_irq;
  logic        timer_irq, sw_irq, global_int_enable, int_ack;
  logic [31:0] mie, mtvec, ack_pc;
  logic        int_req, interrupt_taken;
  logic [31:0] mip_out, interrupt_cause, interrupt_pc, trap_pc;

  int errors = 0;
  int checks = 0;

  int_ctrl #(.NUM_EXT(4)) dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
    .mie(mie), .global_int_enable(global_int_enable), .mtvec(mtvec), .int_ack(int_ack),
    .ack_pc(ack_pc), .int_req(int_req), .mip_out(mip_out), .interrupt_taken(interrupt_taken),
    .interrupt_cause(interrupt_cause), .interrupt_pc(interrupt_pc), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mip, m_cur, m_cause, m_pc, m_trap;
  logic        m_req, m_tkn;
  logic [3:0]  m_prev;
  int          m_phase;  // 0 idle, 1 requesting, 2 taken, 3 blocked

  function automatic logic [31:0] m_enabled(input logic [31:0] en);
    logic [31:0] r;
    r = en & 32'h0000_0088;
    if (en[11]) r = r | (en & 32'h000F_0000);
    return r;
  endfunction

  function automatic logic [31:0] m_prio(input logic [31:0] masked);
    int order [6] = '{16, 17, 18, 19, 3, 7};
    for (int k = 0; k < 6; k++)
      if (masked[order[k]]) return 32'h8000_0000 + 32'(order[k]);
    return 32'h0;
  endfunction

  task automatic model_step();
    logic [31:0] masked, nm, base;
    logic [3:0]  pend;
    logic        elig;
    if (!reset) begin
      m_mip = 0; m_cur = 0; m_cause = 0; m_pc = 0; m_trap = 0;
      m_req = 0; m_tkn = 0; m_prev = 0; m_phase = 0;
      return;
    end
    masked = m_mip & m_enabled(mie);
    elig   = global_int_enable && (masked != 0);
`ifdef INTC_EDGE_TRIG_EN
    pend = m_mip[19:16];
    for (int i = 0; i < 4; i++)
      if (m_phase == 2 && m_cause == 32'h8000_0010 + 32'(i)) pend[i] = 1'b0;
    pend = pend | (ext_irq & ~m_prev);
`else
    pend = ext_irq;
`endif
    nm = {12'd0, pend, 4'd0, (pend != 0), 3'd0, timer_irq, 3'd0, sw_irq, 3'd0};
    m_tkn = 0;
    case (m_phase)
      0: if (elig) begin m_phase = 1; m_req = 1; m_cur = m_prio(masked); end
      1: begin
        if (int_ack) begin
          base = mtvec & ~32'h3;
          if (mtvec % 4 == 1) base = base + 4 * (m_cur % 32);
          m_phase = 2; m_req = 0; m_tkn = 1;
          m_cause = m_cur; m_pc = ack_pc; m_trap = base;
        end else if (!elig) begin
          m_phase = 0; m_req = 0;
        end else m_cur = m_prio(masked);
      end
      2: m_phase = 3;
      default: m_phase = 0;
    endcase
    m_prev = ext_irq;
    m_mip  = nm;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ext_irq = 0; timer_irq = 0; sw_irq = 0; mie = 0; global_int_enable = 0;
    mtvec = 32'h100; int_ack = 0; ack_pc = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    cycle();
    reset = 1;
  endtask

  typedef struct {
    logic rst; logic [3:0] ext; logic tmr; logic sw; logic [31:0] en; logic gie;
    logic [31:0] tvec; logic ack; logic [31:0] apc;
    logic e_req; logic e_tkn; logic [31:0] e_cause, e_pc, e_trap, e_mip;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{0, 4'h0, 0, 0, 32'h80, 1, 32'h100, 0, 32'h0,    0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1, 4'h0, 1, 0, 32'h80, 1, 32'h100, 0, 32'h0,    0, 0, 32'h0, 32'h0, 32'h0, 32'h80};
    tbl[2]  = '{1, 4'h0, 1, 0, 32'h80, 1, 32'h100, 0, 32'h0,    1, 0, 32'h0, 32'h0, 32'h0, 32'h80};
    tbl[3]  = '{1, 4'h0, 1, 0, 32'h80, 1, 32'h100, 1, 32'h2040, 0, 1, 32'h80000007, 32'h2040, 32'h100, 32'h80};
    tbl[4]  = '{1, 4'h0, 0, 0, 32'h80, 1, 32'h100, 0, 32'h0,    0, 0, 32'h80000007, 32'h2040, 32'h100, 32'h0};
    tbl[5]  = '{1, 4'h0, 0, 0, 32'h80, 1, 32'h100, 0, 32'h0,    0, 0, 32'h80000007, 32'h2040, 32'h100, 32'h0};
    tbl[6]  = '{1, 4'h0, 0, 0, 32'h80, 1, 32'h100, 0, 32'h0,    0, 0, 32'h80000007, 32'h2040, 32'h100, 32'h0};
    tbl[7]  = '{1, 4'h2, 0, 0, 32'h20800, 1, 32'h201, 0, 32'h0,    0, 0, 32'h80000007, 32'h2040, 32'h100, 32'h20800};
    tbl[8]  = '{1, 4'h2, 0, 0, 32'h20800, 1, 32'h201, 0, 32'h0,    1, 0, 32'h80000007, 32'h2040, 32'h100, 32'h20800};
    tbl[9]  = '{1, 4'h2, 0, 0, 32'h20800, 1, 32'h201, 1, 32'h3000, 0, 1, 32'h80000011, 32'h3000, 32'h244, 32'h20800};
    tbl[10] = '{1, 4'h0, 0, 0, 32'h20800, 1, 32'h201, 0, 32'h0,    0, 0, 32'h80000011, 32'h3000, 32'h244, 32'h0};
    tbl[11] = '{1, 4'h0, 0, 0, 32'h20800, 1, 32'h201, 0, 32'h0,    0, 0, 32'h80000011, 32'h3000, 32'h244, 32'h0};

    idle_inputs();
    reset = 0;

    for (int r = 0; r < 12; r++) begin
      reset = tbl[r].rst; ext_irq = tbl[r].ext; timer_irq = tbl[r].tmr; sw_irq = tbl[r].sw;
      mie = tbl[r].en; global_int_enable = tbl[r].gie; mtvec = tbl[r].tvec;
      int_ack = tbl[r].ack; ack_pc = tbl[r].apc;
      cycle();
      chk($sformatf("row%0d int_req", r), 32'(int_req), 32'(tbl[r].e_req));
      chk($sformatf("row%0d taken", r), 32'(interrupt_taken), 32'(tbl[r].e_tkn));
      chk($sformatf("row%0d cause", r), interrupt_cause, tbl[r].e_cause);
      chk($sformatf("row%0d pc", r), interrupt_pc, tbl[r].e_pc);
      chk($sformatf("row%0d trap_pc", r), trap_pc, tbl[r].e_trap);
      chk($sformatf("row%0d mip", r), mip_out, tbl[r].e_mip);
    end

    // Withdrawal before acknowledge
    do_reset();
    mie = 32'h80; global_int_enable = 1; timer_irq = 1;
    cycle(); cycle();
    chk("wd req up", 32'(int_req), 32'd1);
    timer_irq = 0;
    cycle();
    chk("wd mip7 low", 32'(mip_out[7]), 32'd0);
    chk("wd req still up", 32'(int_req), 32'd1);
    cycle();
    chk("wd req dropped", 32'(int_req), 32'd0);
    int_ack = 1; ack_pc = 32'h5000;
    cycle();
    chk("wd late ack taken", 32'(interrupt_taken), 32'd0);
    int_ack = 0;
    cycle();
    chk("wd late ack taken2", 32'(interrupt_taken), 32'd0);
    chk("wd late ack pc", interrupt_pc, 32'h0);

    // Preemption by an external line arriving during REQ
    do_reset();
    mie = 32'h00010888; global_int_enable = 1; sw_irq = 1; timer_irq = 1;
    cycle(); cycle();
    chk("pre req up", 32'(int_req), 32'd1);
    ext_irq = 4'h1;
    cycle(); cycle();
    int_ack = 1; ack_pc = 32'h4000;
    cycle();
    chk("pre taken", 32'(interrupt_taken), 32'd1);
    chk("pre cause", interrupt_cause, 32'h80000010);
    chk("pre mip", mip_out, 32'h00010888);
    int_ack = 0; ext_irq = 0; sw_irq = 0; timer_irq = 0;
    cycle();
    chk("pre pulse width", 32'(interrupt_taken), 32'd0);
    cycle(); cycle();

    // Same setup without the external line: software beats timer
    do_reset();
    mie = 32'h00010888; global_int_enable = 1; sw_irq = 1; timer_irq = 1;
    cycle(); cycle();
    int_ack = 1; ack_pc = 32'h4400;
    cycle();
    chk("sw cause", interrupt_cause, 32'h80000003);
    chk("sw trap_pc", trap_pc, 32'h100);
    int_ack = 0; sw_irq = 0; timer_irq = 0;
    cycle(); cycle(); cycle();

    // Global disable gates the request but not the pending image
    global_int_enable = 0; mie = 32'h80; timer_irq = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("gate req %0d", k), 32'(int_req), 32'd0);
      chk($sformatf("gate mip7 %0d", k), 32'(mip_out[7]), 32'd1);
    end

    // Reset while requesting, with an ack presented at the same edge
    global_int_enable = 1;
    cycle();
    chk("rst pre req", 32'(int_req), 32'd1);
    reset = 0; int_ack = 1; ack_pc = 32'h6000;
    cycle();
    chk("rst req", 32'(int_req), 32'd0);
    chk("rst taken", 32'(interrupt_taken), 32'd0);
    chk("rst cause", interrupt_cause, 32'h0);
    chk("rst pc", interrupt_pc, 32'h0);
    chk("rst trap", trap_pc, 32'h0);
    chk("rst mip", mip_out, 32'h0);
    reset = 1; int_ack = 0; timer_irq = 0;
    cycle();
    chk("rst after taken", 32'(interrupt_taken), 32'd0);
    chk("rst after pc", interrupt_pc, 32'h0);

`ifdef INTC_EDGE_TRIG_EN
    // One-cycle pulse is held until its own take
    do_reset();
    mie = 32'h00040800; ext_irq = 4'h4;
    cycle();
    ext_irq = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("edge sticky %0d", k), mip_out, 32'h00040800);
      cycle();
    end
    global_int_enable = 1;
    cycle();
    chk("edge req", 32'(int_req), 32'd1);
    int_ack = 1; ack_pc = 32'h7000;
    cycle();
    chk("edge taken", 32'(interrupt_taken), 32'd1);
    chk("edge cause", interrupt_cause, 32'h80000012);
    chk("edge mip in taken", mip_out, 32'h00040800);
    int_ack = 0;
    cycle();
    chk("edge mip cleared", mip_out, 32'h0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rv;
      reset = ($urandom_range(99) != 0);
      if ($urandom_range(7) == 0) ext_irq = 4'($urandom);
      if ($urandom_range(7) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(9) == 0) sw_irq = ~sw_irq;
      if ($urandom_range(49) == 0) mie = $urandom & 32'h000F_0888;
      if ($urandom_range(49) == 0) begin
        rv = $urandom;
        mtvec = {rv[31:8], 6'd0, rv[1:0]};
      end
      global_int_enable = ($urandom_range(9) != 0);
      int_ack = ($urandom_range(2) == 0);
      ack_pc = $urandom;
      cycle();
      chk("rnd int_req", 32'(int_req), 32'(m_req));
      chk("rnd taken", 32'(interrupt_taken), 32'(m_tkn));
      chk("rnd cause", interrupt_cause, m_cause);
      chk("rnd pc", interrupt_pc, m_pc);
      chk("rnd trap_pc", trap_pc, m_trap);
      chk("rnd mip", mip_out, m_mip);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
